regfile_seq: RTL and testbench

Single-issue instruction sequencer that drives the 16×16-bit, two-read/one-write `registerfile` directly. It accepts a 16-bit instruction over a valid/ready handshake and presents the source addresses on the register file's read ports. It computes the ALU result from `rdata_a`/`rdata_b` and writes the result back through `we`/`waddr`/`wdata`, completing one instruction every 3 cycles.

---
 rtl/regfile_seq_pkg.sv | 15 +
 rtl/regfile_seq_alu.sv | 35 +++
 rtl/registerfile.sv | 19 +
 rtl/regfile_seq.sv | 76 +++++++
 tb/tb_regfile_seq.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg: opcodes, instruction field positions and sequencer states
package regfile_seq_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
    OP_XOR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_MOV = 4'd7,
    OP_LDI = 4'd8, OP_RSV9 = 4'd9, OP_RSV10 = 4'd10, OP_RSV11 = 4'd11,
    OP_RSV12 = 4'd12, OP_RSV13 = 4'd13, OP_RSV14 = 4'd14, OP_RSV15 = 4'd15
  } opcode_t;
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  localparam int IMM_W = 8;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
endpackage

// File: rtl/regfile_seq_alu.sv
// regfile_alu: combinational ALU producing result, carry/borrow and write-back enable
module regfile_alu
  import regfile_seq_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]       op,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic [IMM_W-1:0] imm8,
  output logic [DW-1:0]    result,
  output logic             carry,
  output logic             writes_rd
);
  logic [DW:0] sum, diff;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    result = '0;
    carry = 1'b0;
    writes_rd = op <= 4'(OP_LDI);
    case (opcode_t'(op))
      OP_ADD: {carry, result} = sum;
      OP_SUB: {carry, result} = diff;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: result = a << b[3:0];
      OP_SHR: result = a >> b[3:0];
      OP_MOV: result = a;
      OP_LDI: result = {{(DW-IMM_W){1'b0}}, imm8};
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/registerfile.sv
// registerfile: 2**AW x DW storage, two combinational reads, one synchronous write
module registerfile #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/regfile_seq.sv
// regfile_seq: three-cycle fetch/execute/write-back sequencer driving a 2R1W register file
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [AW-1:0] raddr_a,
  output logic [AW-1:0] raddr_b,
  input  logic [DW-1:0] rdata_a,
  input  logic [DW-1:0] rdata_b,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          done,
  output logic          zero_flag,
  output logic          carry_flag
);
  state_t state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [DW-1:0] res_q, res_d, alu_res;
  logic cy_q, cy_d, zero_q, zero_d, carry_q, carry_d;
  logic alu_cy, alu_wr, accept, commit;
  regfile_alu #(.DW(DW)) u_alu (
    .op       (instr_q[OP_LSB +: 4]),
    .a        (rdata_a),
    .b        (rdata_b),
    .imm8     (instr_q[IMM_W-1:0]),
    .result   (alu_res),
    .carry    (alu_cy),
    .writes_rd(alu_wr)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      res_q <= '0;
      cy_q <= 1'b0;
      zero_q <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      res_q <= res_d;
      cy_q <= cy_d;
      zero_q <= zero_d;
      carry_q <= carry_d;
    end
  end
  always_comb
    state_d = state_q == S_IDLE ? (instr_valid ? S_EXEC : S_IDLE) :
              state_q == S_EXEC ? S_WB : S_IDLE;
  assign accept = state_q == S_IDLE && instr_valid;
  assign commit = state_q == S_WB && alu_wr;
  always_comb begin
    instr_d = accept ? instr : instr_q;
    res_d = state_q == S_EXEC ? alu_res : res_q;
    cy_d = state_q == S_EXEC ? alu_cy : cy_q;
    zero_d = commit ? res_q == '0 : zero_q;
    carry_d = commit ? cy_q : carry_q;
  end
  assign instr_ready = state_q == S_IDLE;
  assign done = state_q == S_WB;
  assign we = commit;
  assign waddr = commit ? instr_q[RD_LSB +: AW] : '0;
  assign wdata = commit ? res_q : '0;
  assign raddr_a = instr_q[RS1_LSB +: AW];
  assign raddr_b = instr_q[RS2_LSB +: AW];
  assign zero_flag = zero_q;
  assign carry_flag = carry_q;
endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq: directed instruction stream checked each cycle against a behavioural ISA model
module tb_regfile_seq;
  logic clk = 0, rst = 0;
  logic [15:0] instr = '0;
  logic instr_valid = 0;
  logic instr_ready, we, done, zero_flag, carry_flag;
  logic [3:0] raddr_a, raddr_b, waddr;
  logic [15:0] rdata_a, rdata_b, wdata;

  always #5 clk = ~clk;

  regfile_seq dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .we(we), .waddr(waddr),
    .wdata(wdata), .done(done), .zero_flag(zero_flag), .carry_flag(carry_flag)
  );

  registerfile u_rf (
    .clk(clk), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b)
  );

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ISA-level model: register array, flags, and cycles elapsed since acceptance
  logic [15:0] m_rf [16];
  logic [15:0] m_ins = '0;
  int cnt = 0;
  bit mz = 0, mc = 0;

  function automatic void model_op(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output bit c, output bit w);
    int unsigned x, y, s;
    x = a;
    y = b;
    s = x + y;
    w = ins[15:12] <= 4'd8;
    c = 0;
    r = '0;
    case (ins[15:12])
      4'd0: begin r = s[15:0]; c = s > 32'hFFFF; end
      4'd1: begin r = a - b; c = x < y; end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[3:0];
      4'd6: r = a >> b[3:0];
      4'd7: r = a;
      4'd8: r = {8'h00, ins[7:0]};
      default: r = '0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [15:0] r;
    bit c, w;
    if (rst) begin
      cnt = 0; m_ins = '0; mz = 0; mc = 0;
    end else if (cnt == 2) begin
      model_op(m_ins, m_rf[m_ins[7:4]], m_rf[m_ins[3:0]], r, c, w);
      if (w) begin
        m_rf[m_ins[11:8]] = r;
        mz = r == 16'h0;
        mc = c;
      end
      cnt = 0;
    end else if (cnt == 1) cnt = 2;
    else if (instr_valid) begin
      m_ins = instr;
      cnt = 1;
    end
  end

  int cyc = 0, last_done = -1, done_cnt = 0;
  bit b2b = 0, on = 0;

  always @(negedge clk) begin
    logic [15:0] r;
    bit c, w;
    cyc++;
    if (on) begin
      model_op(m_ins, m_rf[m_ins[7:4]], m_rf[m_ins[3:0]], r, c, w);
      w = w && cnt == 2;
      chk("ready", instr_ready, cnt == 0);
      chk("done", done, cnt == 2);
      chk("we", we, w);
      if (w) begin
        chk("waddr", waddr, m_ins[11:8]);
        chk("wdata", wdata, r);
      end
      chk("raddr_a", raddr_a, m_ins[7:4]);
      chk("raddr_b", raddr_b, m_ins[3:0]);
      chk("zero_flag", zero_flag, mz);
      chk("carry_flag", carry_flag, mc);
      if (done && b2b) begin
        if (last_done >= 0) chk("done_gap", cyc - last_done, 3);
        last_done = cyc;
        done_cnt++;
      end
    end
  end

  task automatic issue(input logic [15:0] ins, input bit hold = 0);
    int n = 0;
    instr = ins;
    instr_valid = 1;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n == 10) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got ready=0 want ready=1 ins=%h", ins);
    end
    @(negedge clk);
    if (!hold) instr_valid = 0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic rf_check();
    for (int i = 0; i < 16; i++) chk($sformatf("rf%0d", i), u_rf.mem[i], m_rf[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    #1 rst = 1;
    instr = 16'h8FAA;
    instr_valid = 1;
    #1 on = 1;
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_raddr_a", raddr_a, 0);
    chk("rst_raddr_b", raddr_b, 0);
    chk("rst_zero", zero_flag, 0);
    chk("rst_carry", carry_flag, 0);
    repeat (2) @(negedge clk);
    instr_valid = 0;
    #1 rst = 0;
    for (int i = 0; i < 16; i++) issue({4'h8, 4'(i), 8'h00});
    issue(16'h8134);
    issue(16'h8212);
    settle();
    chk("r1_ldi", u_rf.mem[1], 16'h0034);
    chk("r2_ldi", u_rf.mem[2], 16'h0012);
    issue(16'h83FF);
    issue(16'h8808);
    issue(16'h5338);
    issue(16'h0433);
    settle();
    chk("r3_shl", u_rf.mem[3], 16'hFF00);
    chk("r4_add", u_rf.mem[4], 16'hFE00);
    chk("add_carry", carry_flag, 1);
    chk("add_zero", zero_flag, 0);
    issue(16'h1511);
    settle();
    chk("r5_sub", u_rf.mem[5], 16'h0000);
    chk("sub_zero", zero_flag, 1);
    chk("sub_carry", carry_flag, 0);
    issue(16'h1621);
    settle();
    chk("r6_sub", u_rf.mem[6], 16'hFFDE);
    chk("borrow", carry_flag, 1);
    chk("borrow_zero", zero_flag, 0);
    issue(16'hF123);
    settle();
    chk("nop_carry", carry_flag, 1);
    chk("nop_zero", zero_flag, 0);
    rf_check();
    b2b = 1;
    issue(16'h0111, 1);
    issue(16'h7710, 1);
    issue(16'h4A12, 0);
    settle();
    b2b = 0;
    chk("b2b_done_cnt", done_cnt, 3);
    chk("r1_raw", u_rf.mem[1], 16'h0068);
    chk("r7_mov", u_rf.mem[7], 16'h0068);
    chk("r10_xor", u_rf.mem[10], 16'h007A);
    issue(16'h2B34);
    issue(16'h3C12);
    issue(16'h6D38);
    settle();
    chk("r11_and", u_rf.mem[11], 16'hFE00);
    chk("r12_or", u_rf.mem[12], 16'h007A);
    chk("r13_shr", u_rf.mem[13], 16'h00FF);
    issue(16'h8955);
    issue(16'h0912);
    @(posedge clk);
    #1 chk("we_in_wb", we, 1);
    #1 rst = 1;
    #1;
    chk("we_rst_drop", we, 0);
    chk("done_rst_drop", done, 0);
    @(negedge clk);
    #1 rst = 0;
    chk("post_ready", instr_ready, 1);
    chk("post_we", we, 0);
    chk("post_done", done, 0);
    chk("post_waddr", waddr, 0);
    chk("post_wdata", wdata, 0);
    chk("post_raddr_a", raddr_a, 0);
    chk("post_raddr_b", raddr_b, 0);
    chk("post_zero", zero_flag, 0);
    chk("post_carry", carry_flag, 0);
    repeat (3) @(negedge clk);
    chk("r9_kept", u_rf.mem[9], 16'h0055);
    issue(16'h0912);
    settle();
    chk("r9_after", u_rf.mem[9], 16'h007A);
    rf_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
